// File: rtl/data_access_sched_if.sv
// Bundle of all request, response and data-store command signals around one bank scheduler.
//   slave  : the scheduler's view (takes requests, drives readies, responses and da_* commands)
//   master : the requesters' / data-store's view
interface data_access_sched_if #(
    parameter int unsigned LINES_PER_BANK = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned WORD_SIZE      = 4,
    parameter int unsigned TAG_WIDTH      = 8
);
    localparam int unsigned LSW        = $clog2(LINES_PER_BANK);
    localparam int unsigned WSW        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned WORD_WIDTH = 8 * WORD_SIZE;
    localparam int unsigned LINE_WIDTH = WORDS_PER_LINE * WORD_WIDTH;

    logic                  init_done;

    logic                  fill_valid;
    logic                  fill_ready;
    logic [LSW-1:0]        fill_addr;
    logic [LINE_WIDTH-1:0] fill_data;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [LSW-1:0]        wr_addr;
    logic [WSW-1:0]        wr_wsel;
    logic [WORD_SIZE-1:0]  wr_byteen;
    logic [WORD_WIDTH-1:0] wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [LSW-1:0]        rd_addr;
    logic [WSW-1:0]        rd_wsel;
    logic [TAG_WIDTH-1:0]  rd_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic [WORD_WIDTH-1:0] rsp_data;

    logic                  da_fill;
    logic                  da_write;
    logic                  da_read;
    logic [LSW-1:0]        da_addr;
    logic [WSW-1:0]        da_wsel;
    logic [WORD_SIZE-1:0]  da_byteen;
    logic [LINE_WIDTH-1:0] da_fill_data;
    logic [WORD_WIDTH-1:0] da_write_data;
    logic [WORD_WIDTH-1:0] da_read_data;

    modport slave (
        output init_done,
        input  fill_valid, fill_addr, fill_data,
        output fill_ready,
        input  wr_valid, wr_addr, wr_wsel, wr_byteen, wr_data,
        output wr_ready,
        input  rd_valid, rd_addr, rd_wsel, rd_tag,
        output rd_ready,
        output rsp_valid, rsp_tag, rsp_data,
        input  rsp_ready,
        output da_fill, da_write, da_read, da_addr, da_wsel, da_byteen, da_fill_data,
        output da_write_data,
        input  da_read_data
    );

    modport master (
        input  init_done,
        output fill_valid, fill_addr, fill_data,
        input  fill_ready,
        output wr_valid, wr_addr, wr_wsel, wr_byteen, wr_data,
        input  wr_ready,
        output rd_valid, rd_addr, rd_wsel, rd_tag,
        input  rd_ready,
        input  rsp_valid, rsp_tag, rsp_data,
        output rsp_ready,
        input  da_fill, da_write, da_read, da_addr, da_wsel, da_byteen, da_fill_data,
        input  da_write_data,
        output da_read_data
    );
endinterface

// File: rtl/data_access_sched.sv
// Per-bank scheduler in front of a single-ported cache line store.
// After reset it zeroes every line, then grants one of fill / write / read per cycle
// (fill > write > read, with a starvation promotion for reads), registers the winning
// command onto da_*, and returns read words through a 2-entry tagged response FIFO.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   bus         data_access_sched_if.slave: request handshakes, response handshake,
//               da_* command outputs and da_read_data from the store, init_done
module data_access_sched #(
    parameter int unsigned LINES_PER_BANK = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned WORD_SIZE      = 4,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input logic                clk,
    input logic                reset,
    data_access_sched_if.slave bus
);
    localparam int unsigned LSW        = $clog2(LINES_PER_BANK);
    localparam int unsigned WSW        = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int unsigned WORD_WIDTH = 8 * WORD_SIZE;
    localparam int unsigned LINE_WIDTH = WORDS_PER_LINE * WORD_WIDTH;
    localparam int unsigned SCW        = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned RSPW       = TAG_WIDTH + WORD_WIDTH;
    localparam logic [LSW-1:0] LastLine  = LSW'(LINES_PER_BANK - 1);
    localparam logic [SCW-1:0] StarveMax = SCW'(STARVE_LIMIT);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [LSW-1:0]        line_q, line_d;
    logic                  init_done_q;
    logic [SCW-1:0]        starve_q, starve_d;

    logic                  da_fill_q, da_fill_d;
    logic                  da_write_q, da_write_d;
    logic                  da_read_q, da_read_d;
    logic [LSW-1:0]        da_addr_q, da_addr_d;
    logic [WSW-1:0]        da_wsel_q, da_wsel_d;
    logic [WORD_SIZE-1:0]  da_byteen_q, da_byteen_d;
    logic [LINE_WIDTH-1:0] da_fill_data_q, da_fill_data_d;
    logic [WORD_WIDTH-1:0] da_write_data_q, da_write_data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    logic [RSPW-1:0]       fifo_mem_q [2];
    logic                  fifo_wptr_q, fifo_rptr_q;
    logic [1:0]            fifo_cnt_q;
    logic                  push, pop;

    logic [1:0]            pending;
    logic                  rd_elig, starved;
    logic                  fill_gnt, wr_gnt, rd_gnt;

    // Arbitration. pending counts the read on the store this cycle as well as the FIFO
    // contents, so the FIFO can never be asked to hold a third entry.
    always_comb begin
        pending  = fifo_cnt_q + {1'b0, da_read_q};
        rd_elig  = (pending < 2'd2);
        starved  = (starve_q == StarveMax);
        fill_gnt = 1'b0;
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        if (init_done_q) begin
            if (bus.fill_valid) begin
                fill_gnt = 1'b1;
            end else if (bus.rd_valid && rd_elig && (starved || !bus.wr_valid)) begin
                rd_gnt = 1'b1;
            end else if (bus.wr_valid) begin
                wr_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (rd_gnt) begin
            starve_d = '0;
        end else if (init_done_q && bus.rd_valid && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Sweep FSM and command issue; data fields hold when nothing is issued.
    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        da_fill_d       = 1'b0;
        da_write_d      = 1'b0;
        da_read_d       = 1'b0;
        da_addr_d       = da_addr_q;
        da_wsel_d       = da_wsel_q;
        da_byteen_d     = da_byteen_q;
        da_fill_data_d  = da_fill_data_q;
        da_write_data_d = da_write_data_q;
        tag_d           = tag_q;
        case (state_q)
            StInit: begin
                da_fill_d      = 1'b1;
                da_addr_d      = line_q;
                da_fill_data_d = '0;
                da_byteen_d    = '0;
                line_d         = line_q + 1'b1;
                if (line_q == LastLine) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fill_gnt) begin
                    da_fill_d      = 1'b1;
                    da_addr_d      = bus.fill_addr;
                    da_fill_data_d = bus.fill_data;
                    da_byteen_d    = '0;
                end else if (wr_gnt) begin
                    da_write_d      = 1'b1;
                    da_addr_d       = bus.wr_addr;
                    da_wsel_d       = bus.wr_wsel;
                    da_byteen_d     = bus.wr_byteen;
                    da_write_data_d = bus.wr_data;
                end else if (rd_gnt) begin
                    da_read_d   = 1'b1;
                    da_addr_d   = bus.rd_addr;
                    da_wsel_d   = bus.rd_wsel;
                    da_byteen_d = '0;
                    tag_d       = bus.rd_tag;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign push = da_read_q;
    assign pop  = (fifo_cnt_q != 2'd0) && bus.rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StInit;
            line_q          <= '0;
            init_done_q     <= 1'b0;
            starve_q        <= '0;
            da_fill_q       <= 1'b0;
            da_write_q      <= 1'b0;
            da_read_q       <= 1'b0;
            da_addr_q       <= '0;
            da_wsel_q       <= '0;
            da_byteen_q     <= '0;
            da_fill_data_q  <= '0;
            da_write_data_q <= '0;
            tag_q           <= '0;
            fifo_mem_q[0]   <= '0;
            fifo_mem_q[1]   <= '0;
            fifo_wptr_q     <= 1'b0;
            fifo_rptr_q     <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            state_q         <= state_d;
            line_q          <= line_d;
            // Rises the cycle after the last sweep command is on the store.
            init_done_q     <= init_done_q | (state_q == StRun);
            starve_q        <= starve_d;
            da_fill_q       <= da_fill_d;
            da_write_q      <= da_write_d;
            da_read_q       <= da_read_d;
            da_addr_q       <= da_addr_d;
            da_wsel_q       <= da_wsel_d;
            da_byteen_q     <= da_byteen_d;
            da_fill_data_q  <= da_fill_data_d;
            da_write_data_q <= da_write_data_d;
            tag_q           <= tag_d;
            if (push) begin
                fifo_mem_q[fifo_wptr_q] <= {tag_q, bus.da_read_data};
                fifo_wptr_q             <= ~fifo_wptr_q;
            end
            if (pop) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.init_done     = init_done_q;
    assign bus.fill_ready    = fill_gnt;
    assign bus.wr_ready      = wr_gnt;
    assign bus.rd_ready      = rd_gnt;
    assign bus.rsp_valid     = (fifo_cnt_q != 2'd0);
    assign bus.rsp_tag       = fifo_mem_q[fifo_rptr_q][RSPW-1:WORD_WIDTH];
    assign bus.rsp_data      = fifo_mem_q[fifo_rptr_q][WORD_WIDTH-1:0];
    assign bus.da_fill       = da_fill_q;
    assign bus.da_write      = da_write_q;
    assign bus.da_read       = da_read_q;
    assign bus.da_addr       = da_addr_q;
    assign bus.da_wsel       = da_wsel_q;
    assign bus.da_byteen     = da_byteen_q;
    assign bus.da_fill_data  = da_fill_data_q;
    assign bus.da_write_data = da_write_data_q;
endmodule
